// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, frame constants
// and small helpers used for the FIFO level width and divider clamping.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A bit period below two clocks would leave no room for the last-cycle compare.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; DEPTH must be a power of 2.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [clog2(DEPTH):0]  level_o
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o     = (level_q == (PW+1)'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push against a full FIFO is refused even if a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PW+1)'(1);
            2'b01:   level_d = level_q - (PW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small FIFO; frames go out back-to-back while data is queued.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DEFAULT_DIV = 106
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            cfg_div,
    input  logic                   cfg_div_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [clog2(DEPTH):0]  level
);

    uart_state_e state_q, state_d;
    logic [31:0] div_eff_q, div_eff_d;
    logic [31:0] div_cnt_q, div_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        fifo_full, fifo_empty, pop, launch, last;
    logic [7:0]  head;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_valid),
        .push_data_i (in_data),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign last     = (div_cnt_q == div_eff_q - 32'd1);

    always_comb begin
        state_d   = state_q;
        div_eff_d = div_eff_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        launch    = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) launch = 1'b1;
            end
            ST_START: begin
                if (last) begin
                    state_d   = ST_DATA;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            ST_DATA: begin
                if (last) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (last) begin
                    state_d   = ST_STOP;
                    div_cnt_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
`endif
            ST_STOP: begin
                if (last) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        div_cnt_d = '0;
                        tx_d      = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (launch) begin
            pop       = 1'b1;
            shift_d   = head;
`ifdef UART_TX_PARITY_EN
            par_d     = ^head;
`endif
            div_eff_d = clamp_div(cfg_div_valid ? cfg_div : 32'(DEFAULT_DIV));
            state_d   = ST_START;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_eff_q <= 32'(MIN_DIV);
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_eff_q <= div_eff_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-timeline reference model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_tx_fifo;

    localparam int DEPTH       = 4;
    localparam int DEFAULT_DIV = 106;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cfg_div;
    logic        cfg_div_valid;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_div       (cfg_div),
        .cfg_div_valid (cfg_div_valid),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tx            (tx),
        .busy          (busy),
        .level         (level)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of bytes and the timeline of the frame on the wire.
    logic [7:0]  mq[$];
    bit          m_active = 1'b0;
    int          m_start  = 0;
    int          m_d      = 2;
    int          m_e      = 0;
    logic [10:0] m_bits   = '1;
    bit          m_pushed = 1'b0;

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic step();
        logic        p_rst, p_v, p_cv;
        logic [7:0]  p_dat;
        logic [31:0] p_cd, dsel;
        bit          can_push;
        logic        exp_tx;
        p_rst = reset; p_v = in_valid; p_dat = in_data; p_cv = cfg_div_valid; p_cd = cfg_div;
        @(posedge clk);
        m_e++;
        m_pushed = 1'b0;
        if (p_rst) begin
            mq.delete();
            m_active = 1'b0;
        end else begin
            can_push = p_v && (mq.size() != DEPTH);
            if (m_active && (m_e - m_start == NBITS * m_d)) m_active = 1'b0;
            if (!m_active && mq.size() != 0) begin
                m_bits   = frame_bits(mq.pop_front());
                dsel     = p_cv ? p_cd : 32'(DEFAULT_DIV);
                m_d      = (dsel < 32'd2) ? 2 : int'(dsel);
                m_start  = m_e;
                m_active = 1'b1;
            end
            if (can_push) begin
                mq.push_back(p_dat);
                m_pushed = 1'b1;
            end
        end
        #1;
        exp_tx = m_active ? m_bits[(m_e - m_start) / m_d] : 1'b1;
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("level", 32'(level), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("busy", 32'(busy), 32'(m_active || mq.size() != 0));
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        m_pushed = 1'b0;
        while (!m_pushed && n < 5000) begin
            step();
            n++;
        end
        chk("send_accepted", 32'(m_pushed), 32'd1);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (busy !== 1'b0 && n < maxc) begin
            step();
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
        step();
    endtask

    logic [7:0] burst [5];

    initial begin
        burst[0] = 8'h48; burst[1] = 8'h69; burst[2] = 8'h21; burst[3] = 8'h0A; burst[4] = 8'h41;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_div = '0; cfg_div_valid = 1'b0;
        step();
        step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        step();

        // Single byte at the default bit time; tx falls one edge after the push.
        send(8'h55);
        chk("launch_latency_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        step();
        chk("launch_latency_tx", 32'(tx), 32'd0);
        drain(1200);

        // Burst with in_valid held: FIFO fills after the first byte is launched.
        for (int i = 0; i < 5; i++) send(burst[i]);
        in_valid = 1'b0;
        chk("burst_level", 32'(level), 32'd4);
        chk("burst_full_rdy", 32'(in_ready), 32'd0);
        drain(7000);

        // Divider clamp to two clocks per bit.
        cfg_div_valid = 1'b1;
        cfg_div = 32'd0;
        send(8'hFF);
        drain(100);
        cfg_div = 32'd1;
        send(8'h5A);
        drain(100);

        // Divider change mid-frame applies only from the next launch.
        cfg_div = 32'd10;
        send(8'hC3);
        send(8'h3C);
        in_valid = 1'b0;
        repeat (30) step();
        cfg_div = 32'd20;
        drain(1000);

`ifdef UART_TX_PARITY_EN
        cfg_div = 32'd4;
        send(8'h07);
        send(8'h03);
        drain(200);
`endif

        // Reset during data bit 3 of 0xA5 with two more bytes queued.
        cfg_div = 32'd10;
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        in_valid = 1'b0;
        repeat (43) step();
        reset = 1'b1;
        step();
        chk("rmid_tx", 32'(tx), 32'd1);
        chk("rmid_level", 32'(level), 32'd0);
        reset = 1'b0;
        repeat (300) step();
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_tx_idle", 32'(tx), 32'd1);

        // Random traffic, divider churn and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_data       = 8'($urandom);
            cfg_div_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) cfg_div = 32'($urandom_range(0, 9));
            reset         = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        cfg_div_valid = 1'b1;
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
